// File: rtl/spi_rx_deser.sv
// SPI receive stage: synchronises spi_clk/spi_data into clk, assembles MSB-first bytes and
// queues them in a 2-entry FIFO. Define SPI_RX_OVR_CNT_EN to add the ovr_count drop counter.
module spi_rx_deser #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    input  logic       clr_ovr,
    output logic       frame_drop
`ifdef SPI_RX_OVR_CNT_EN
    ,
    output logic [7:0] ovr_count
`endif
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(IDLE_TIMEOUT);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   sclk_dly_q;

    logic [7:0]      shift_q,      shift_d;
    logic [2:0]      bit_cnt_q,    bit_cnt_d;
    logic [7:0]      idle_cnt_q,   idle_cnt_d;
    logic [1:0][7:0] mem_q,        mem_d;
    logic            wr_ptr_q,     wr_ptr_d;
    logic            rd_ptr_q,     rd_ptr_d;
    logic [1:0]      count_q,      count_d;
    logic            overrun_q,    overrun_d;
    logic            frame_drop_q, frame_drop_d;

    logic       sclk_s;
    logic       data_s;
    logic       sclk_rise;
    logic       byte_done;
    logic       timeout;
    logic       pop;
    logic       full;
    logic       drop;
    logic       push_ok;
    logic [7:0] byte_new;

    // Both inputs travel through equal-depth chains, so data_s stays aligned with sclk_s.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign byte_new  = {shift_q[6:0], data_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign timeout   = !sclk_rise && (idle_cnt_q == TIMEOUT_CNT);

    // A full buffer still accepts a byte when the consumer pops in the same cycle.
    assign pop     = (count_q != 2'd0) && rx_ready;
    assign full    = (count_q == 2'd2);
    assign drop    = byte_done && full && !pop;
    assign push_ok = byte_done && !drop;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        frame_drop_d = 1'b0;

        if (sclk_rise) begin
            shift_d   = byte_new;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (timeout) begin
            shift_d      = 8'h00;
            bit_cnt_d    = 3'd0;
            frame_drop_d = 1'b1;
        end

        if (sclk_rise || (bit_cnt_q == 3'd0)) begin
            idle_cnt_d = 8'h00;
        end else if (idle_cnt_q != 8'hFF) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = byte_new;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as clr_ovr keeps the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q  <= '0;
            data_sync_q  <= '0;
            sclk_dly_q   <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            idle_cnt_q   <= 8'h00;
            // NOTE: buffer storage is reset as well, so rx_data reads 8'h00 during reset.
            mem_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            overrun_q    <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], spi_data};
            sclk_dly_q   <= sclk_s;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_valid   = (count_q != 2'd0);
    assign overrun    = overrun_q;
    assign frame_drop = frame_drop_q;

`ifdef SPI_RX_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        if (clr_ovr) begin
            ovr_cnt_d = {7'd0, drop};
        end else if (drop && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_cnt_q <= 8'h00;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_count = ovr_cnt_q;
`endif

endmodule
